// File: rtl/logic_ops_pkg.sv
// Shared opcode and state encodings for the logic-operation sequencer and its unit bank.
package logic_ops_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_bank.sv
// Combinational bank of AND/OR/XOR/NOT units with a result mux selected by opcode.
module logic_unit_bank
  import logic_ops_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic            en,
  input  op_e             op,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   y,
  output logic [2*DW-1:0] result
);

  logic [DW-1:0]   and_r;
  logic [DW-1:0]   or_r;
  logic [DW-1:0]   xor_r;
  logic [2*DW-1:0] not_r;

  // Units see forced-zero operands when disabled so they stay quiet outside EXEC.
  logic [DW-1:0] x_g;
  logic [DW-1:0] y_g;

  assign x_g   = en ? x : '0;
  assign y_g   = en ? y : '0;
  assign and_r = x_g & y_g;
  assign or_r  = x_g | y_g;
  assign xor_r = x_g ^ y_g;
  assign not_r = en ? ~{x_g, y_g} : '0;

  // NOTE: every output of an always_comb gets a value on every path (here via the
  // default arm), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = {{DW{1'b0}}, and_r};
      OP_OR:   result = {{DW{1'b0}}, or_r};
      OP_XOR:  result = {{DW{1'b0}}, xor_r};
      OP_NOT:  result = not_r;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Valid/ready front end: latches a command, runs it through the unit bank for one
// cycle, then holds the result until the consumer takes it.
module logic_op_sequencer
  import logic_ops_pkg::*;
#(
  parameter int DW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_x,
  input  logic [DW-1:0]    cmd_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*DW-1:0]  res_data,
  output logic [1:0]       res_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DW-1:0]     x_q;
  logic [DW-1:0]     y_q;
  logic [2*DW-1:0]   res_data_q;
  op_e               res_op_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept;
  logic              capture;
  logic              done;
  logic              unit_en;
  logic [2*DW-1:0]   bank_result;

  logic_unit_bank #(.DW(DW)) u_bank (
    .en     (unit_en),
    .op     (op_q),
    .x      (x_q),
    .y      (y_q),
    .result (bank_result)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples its
  // inputs from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unit_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unit_en = 1'b1;
        capture = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Operands are frozen at acceptance so later cmd_* activity cannot disturb the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_AND;
      x_q  <= '0;
      y_q  <= '0;
    end else if (accept) begin
      op_q <= op_e'(cmd_op);
      x_q  <= cmd_x;
      y_q  <= cmd_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q <= '0;
      res_op_q   <= OP_AND;
    end else if (capture) begin
      res_data_q <= bank_result;
      res_op_q   <= op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count_q <= '0;
    else if (done) count_q <= count_q + CNT_W'(1);
  end

  assign res_data = res_data_q;
  assign res_op   = res_op_q;
  assign op_count = count_q;

endmodule
